// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the small FP format used by the MAC array and its
// output packer: {sign, exponent, mantissa}, no NaN/Inf encodings.
// Provides default field widths, bias constants, field-extract helpers and the
// positive-zero constant.
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam int unsigned FP_WIDTH = 8;
    localparam int unsigned FP_EXP   = 4;
    localparam int unsigned FP_MTS   = 3;

    localparam int unsigned BIAS    = 2 ** (FP_EXP - 1) - 1;
    localparam int unsigned EXP_MAX = 2 ** FP_EXP - 2;

    localparam logic [FP_WIDTH-1:0] FP_ZERO = '0;

    function automatic logic fp_sign(input logic [FP_WIDTH-1:0] x);
        return x[FP_WIDTH-1];
    endfunction

    function automatic logic [FP_EXP-1:0] fp_exp(input logic [FP_WIDTH-1:0] x);
        return x[FP_MTS +: FP_EXP];
    endfunction

    function automatic logic [FP_MTS-1:0] fp_mts(input logic [FP_WIDTH-1:0] x);
        return x[FP_MTS-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through FIFO with synchronous active-high reset.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_data      write request and data; ignored when full unless a
//                       pop happens in the same cycle
//   o_full              FIFO holds DEPTH words
//   i_pop               pop request; ignored when empty
//   o_data, o_empty     head word (0 when empty) and empty flag
//   o_level             number of words held, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_full,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_cnt;
    logic [AW:0]       r_rd_cnt;

    logic [AW:0] w_level;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;

    // Counters carry one extra bit so full and empty are distinguishable.
    assign w_level = r_wr_cnt - r_rd_cnt;
    assign w_full  = (w_level == (AW + 1)'(DEPTH));
    assign w_empty = (w_level == '0);
    assign w_pop   = i_pop && !w_empty;
    // A pop frees the head slot at this edge, so a full FIFO can still accept.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_mem[r_wr_cnt[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_cnt[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = w_level;

endmodule

// File: rtl/fp_out_packer.sv
// ----------------------------------------------------------------------------
// fp_out_packer
// Takes one FP result per vld_i pulse, optionally clamps negatives to +0,
// packs LANES results into one word and streams words out through a FWFT FIFO.
// The upstream MAC cannot stall, so words arriving at a full FIFO are dropped
// and flagged with a sticky error.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   acc_i, vld_i FP result and its single-cycle valid
//   flush_i      emit a partially filled word, unfilled lanes zero
//   out_data     packed word, lane 0 in the least significant bits
//   out_valid    out_data valid; out_ready accepts it
//   level_o      words held in the FIFO
//   drop_err     sticky: a completed word was dropped on FIFO full
// ----------------------------------------------------------------------------
module fp_out_packer
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,
    parameter int unsigned EXP   = FP_EXP,
    parameter int unsigned MTS   = FP_MTS,
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 4,
    parameter bit          RELU  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         acc_i,
    input  logic                     vld_i,
    input  logic                     flush_i,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_err
);

    localparam int unsigned LCW = $clog2(LANES);

    logic [LCW-1:0]         r_lane_cnt;
    logic [LANES*WIDTH-1:0] r_pack;
    logic                   r_drop_err;

    logic [WIDTH-1:0]       w_val;
    logic [LANES*WIDTH-1:0] w_word;
    logic                   w_last_lane;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;

    // ReLU: any set sign bit (including -0) becomes +0.
    assign w_val = (RELU && acc_i[WIDTH-1]) ? '0 : acc_i;

    // Current pack register with this cycle's result merged in, so a
    // completing or flushed word includes the same-cycle value.
    always_comb begin
        w_word = r_pack;
        for (int l = 0; l < int'(LANES); l++) begin
            if (vld_i && (r_lane_cnt == LCW'(l))) begin
                w_word[l*WIDTH +: WIDTH] = w_val;
            end
        end
    end

    assign w_last_lane = (r_lane_cnt == LCW'(LANES - 1));
    // Word completion and flush together still produce a single push.
    assign w_push = (vld_i && w_last_lane) ||
                    (flush_i && ((r_lane_cnt != '0) || vld_i));
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_pack     <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_lane_cnt <= '0;
                r_pack     <= '0;
            end else if (vld_i) begin
                r_lane_cnt <= r_lane_cnt + 1'b1;
                r_pack     <= w_word;
            end
            if (w_push && w_full && !w_pop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .DATA_W (LANES * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_word),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    // Derived from FIFO state only; never from out_ready.
    assign out_valid = !w_empty;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_fp_out_packer.sv
module tb_fp_out_packer;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int D  = 4;
    localparam int OW = L * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  acc_i = '0;
    logic          vld_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          out_ready = 1'b0;

    // Index 0: RELU=1 instance, index 1: RELU=0 instance; both share stimulus.
    logic [OW-1:0] od [2];
    logic          ov [2];
    logic [2:0]    lvl [2];
    logic          derr [2];

    fp_out_packer #(.WIDTH(W), .EXP(4), .MTS(3), .LANES(L), .DEPTH(D), .RELU(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .acc_i(acc_i), .vld_i(vld_i), .flush_i(flush_i),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .level_o(lvl[0]), .drop_err(derr[0])
    );

    fp_out_packer #(.WIDTH(W), .EXP(4), .MTS(3), .LANES(L), .DEPTH(D), .RELU(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .acc_i(acc_i), .vld_i(vld_i), .flush_i(flush_i),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .level_o(lvl[1]), .drop_err(derr[1])
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model state.
    logic [W-1:0]  lanes_q [$];
    logic [OW-1:0] exp0 [$];
    logic [OW-1:0] exp1 [$];
    int            mlevel = 0;
    bit            mdrop  = 0;

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
        return v[W-1] ? '0 : v;
    endfunction

    task automatic post_edge_checks();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("level[%0d]", k), 64'(lvl[k]), 64'(mlevel));
            check($sformatf("valid[%0d]", k), 64'(ov[k]), 64'(mlevel > 0));
            check($sformatf("drop_err[%0d]", k), 64'(derr[k]), 64'(mdrop));
        end
    endtask

    // One clock cycle of stimulus; the model predicts what the edge does.
    task automatic cyc(input bit v, input logic [W-1:0] a, input bit f, input bit r);
        logic [OW-1:0] w0, w1;
        bit pop;
        vld_i = v; acc_i = a; flush_i = f; out_ready = r;
        pop = r && (mlevel > 0);
        if (v) lanes_q.push_back(a);
        if (lanes_q.size() == L || (f && lanes_q.size() > 0)) begin
            w0 = '0; w1 = '0;
            foreach (lanes_q[i]) begin
                w0 = w0 | (OW'(relu(lanes_q[i])) << (W * i));
                w1 = w1 | (OW'(lanes_q[i]) << (W * i));
            end
            lanes_q.delete();
            if (mlevel < D || pop) begin
                exp0.push_back(w0);
                exp1.push_back(w1);
                mlevel++;
            end else begin
                mdrop = 1;
            end
        end
        if (pop) mlevel--;
        @(posedge clk); #1;
        post_edge_checks();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; vld_i = 0; flush_i = 0; out_ready = 0;
        lanes_q.delete(); exp0.delete(); exp1.delete();
        mlevel = 0; mdrop = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        post_edge_checks();
        check("reset out_data", 64'(od[0]), 64'(0));
    endtask

    task automatic feed_words(input int nw, input bit r);
        for (int i = 0; i < nw * L; i++) cyc(1, W'($urandom), 0, r);
    endtask

    // Scoreboard monitor: compares every accepted beat and checks stall stability.
    bit            prev_stall [2] = '{0, 0};
    logic [OW-1:0] prev_data  [2];

    always @(negedge clk) begin
        logic [OW-1:0] e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                prev_stall[k] = 0;
            end else begin
                if (prev_stall[k]) begin
                    check($sformatf("stall valid[%0d]", k), 64'(ov[k]), 64'(1));
                    check($sformatf("stall data[%0d]", k), 64'(od[k]), 64'(prev_data[k]));
                end
                if (ov[k] && out_ready) begin
                    if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
                        check($sformatf("unexpected word[%0d]", k), 64'(od[k]), 64'hDEAD);
                    end else begin
                        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                        check($sformatf("word[%0d]", k), 64'(od[k]), 64'(e));
                    end
                end
                prev_stall[k] = ov[k] && !out_ready;
                prev_data[k]  = od[k];
            end
        end
    end

    initial begin
        // T1: reset mid-word discards partial data.
        do_reset(2);
        cyc(1, 8'h11, 0, 1);
        cyc(1, 8'h22, 0, 1);
        do_reset(2);
        // T2: full word, ReLU on lane 1.
        cyc(1, 8'h38, 0, 1); cyc(1, 8'hB8, 0, 1); cyc(1, 8'h40, 0, 1); cyc(1, 8'h00, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        // T3: flush of partial word, then flush of empty pack.
        cyc(1, 8'h38, 0, 1); cyc(1, 8'h44, 0, 1); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        // Completing vld with same-cycle flush: one push only.
        cyc(1, 8'h01, 0, 1); cyc(1, 8'h02, 0, 1); cyc(1, 8'h03, 0, 1); cyc(1, 8'h04, 1, 1);
        cyc(1, 8'h05, 1, 1); cyc(0, 0, 0, 1);
        // T4: backpressure, fifth word dropped, then drain in order.
        feed_words(D + 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (D + 2) cyc(0, 0, 0, 1);
        // T5: full FIFO with pop on the same edge as the completing vld.
        do_reset(1);
        feed_words(D, 0);
        cyc(1, 8'hA1, 0, 0); cyc(1, 8'hA2, 0, 0); cyc(1, 8'hA3, 0, 0); cyc(1, 8'hA4, 0, 1);
        repeat (D + 2) cyc(0, 0, 0, 1);
        // T6: negative zero and negative value (pass-through in instance 1).
        cyc(1, 8'h80, 0, 1); cyc(1, 8'hC8, 1, 1); cyc(0, 0, 0, 1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else cyc($urandom_range(0, 1), W'($urandom), $urandom_range(0, 19) == 0,
                     $urandom_range(0, 9) < 6);
        end
        repeat (D + 4) cyc(0, 0, 0, 1);
        check("exp0 drained", 64'(exp0.size()), 64'(0));
        check("exp1 drained", 64'(exp1.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
